// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding and
// issue-mode constants.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_STEP = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/edge_rise.sv
// Synchronous rising-edge detector. The history flop resets to 1 so a
// level already high when reset releases produces no edge.
module edge_rise (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign edge_o = level_i & ~prev_q;

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: small instruction memory issued over valid/ready in
// step or run mode. Define SEQ_ISSUE_COUNT_EN to add the issue_cnt output.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int INSTR_W = 22,
    parameter int DEPTH   = 32,
    parameter int PC_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               loop_en,
    input  logic [PC_W:0]      prog_len,
    input  logic               start,
    input  logic               step,
    input  logic               abort,
    input  logic               wr_en,
    input  logic [PC_W-1:0]    wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    output logic [INSTR_W-1:0] instr_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done
`ifdef SEQ_ISSUE_COUNT_EN
    ,
    output logic [15:0]        issue_cnt
`endif
);

    localparam logic [PC_W:0] DEPTH_L = (PC_W + 1)'(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    state_e        state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W:0] len_q;
    logic [PC_W:0] len_d;
    logic          mode_q;
    logic          loop_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          start_edge;
    logic          step_edge;
    logic          hs;
    logic          last;

    edge_rise u_start_edge (
        .clk_i   (clk),
        .rst_i   (rst),
        .level_i (start),
        .edge_o  (start_edge)
    );

    edge_rise u_step_edge (
        .clk_i   (clk),
        .rst_i   (rst),
        .level_i (step),
        .edge_o  (step_edge)
    );

    assign len_d = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign hs    = valid_q & instr_ready;
    assign last  = ({1'b0, pc_q} == (len_q - 1'b1));

    // Program is frozen while a run is in flight.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            mode_q  <= MODE_STEP;
            loop_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_edge) begin
                        mode_q <= mode;
                        loop_q <= loop_en;
                        len_q  <= len_d;
                        pc_q   <= '0;
                        done_q <= 1'b0;
                        if (len_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (mode == MODE_RUN) begin
                            state_q <= ISSUE;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ARM;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (step_edge) begin
                        state_q <= ISSUE;
                        valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        if (last && !loop_q) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q <= last ? '0 : pc_q + 1'b1;
                            if (mode_q == MODE_STEP) begin
                                state_q <= ARM;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_ISSUE_COUNT_EN
    logic [15:0] cnt_q;

    // An aborted cycle's handshake was still taken by the coprocessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!abort && start_edge &&
                     (state_q == IDLE || state_q == DONE)) begin
            cnt_q <= '0;
        end else if (hs) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign issue_cnt = cnt_q;
`endif

    assign instr_data  = mem_q[pc_q];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: issue order is predicted from the
// program array as entry (n mod eff_len) for the n-th accepted handshake.
module tb_instr_sequencer;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        loop_en;
    logic [5:0]  prog_len;
    logic        start;
    logic        step;
    logic        abort;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [21:0] wr_data;
    logic [21:0] instr_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
`ifdef SEQ_ISSUE_COUNT_EN
    logic [15:0] issue_cnt;
`endif

    logic [21:0] mem_m [DEPTH];
    bit          sp_prev;
    int          checks;
    int          errors;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .loop_en     (loop_en),
        .prog_len    (prog_len),
        .start       (start),
        .step        (step),
        .abort       (abort),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_ISSUE_COUNT_EN
        ,
        .issue_cnt   (issue_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // The detector history sees step at each edge, or 1 under reset.
    task automatic tick();
        @(posedge clk);
        sp_prev = rst ? 1'b1 : step;
        @(negedge clk);
    endtask

    task automatic write_mem(input int addr, input logic [21:0] data,
                             input bit upd);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (upd) mem_m[addr] = data;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_pc"}, {27'd0, pc}, 0);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort");
    endtask

    // rdy_mode: 0 = ready held high, 1 = random, 2 = pattern 1,0,0,1.
    task automatic run_prog(input int plen, input bit md, input bit lp,
                            input int rdy_mode, input int cycles);
        int len;
        int n;
        int k;
        bit fin;
        bit iss;
        bit rdy;
        bit edge_s;
        len      = (plen > DEPTH) ? DEPTH : plen;
        mode     = md;
        loop_en  = lp;
        prog_len = 6'(plen);
        start    = 1'b1;
        tick();
        start = 1'b0;
        n   = 0;
        fin = (len == 0);
        iss = md && !fin;
        for (k = 0; k < cycles; k++) begin
            chk("valid", {31'd0, instr_valid}, {31'd0, iss});
            chk("busy", {31'd0, busy}, {31'd0, !fin});
            chk("done", {31'd0, done}, {31'd0, fin});
            if (!fin) begin
                chk("pc", {27'd0, pc}, n % len);
                if (iss) chk("data", {10'd0, instr_data},
                             {10'd0, mem_m[n % len]});
            end else begin
                chk("pc_end", {27'd0, pc}, (len == 0) ? 0 : len - 1);
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (k % 4 == 0) || (k % 4 == 3);
            endcase
            instr_ready = rdy;
            if (!md) step = 1'($urandom_range(0, 1));
            edge_s = step && !sp_prev;
            if (iss && rdy) begin
                n++;
                if (!lp && n == len) fin = 1'b1;
                iss = md && !fin;
            end else if (!md && !iss && !fin && edge_s) begin
                iss = 1'b1;
            end
            tick();
        end
        step        = 1'b0;
        instr_ready = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        mode        = 1'b0;
        loop_en     = 1'b0;
        prog_len    = '0;
        start       = 1'b0;
        step        = 1'b0;
        abort       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        instr_ready = 1'b0;
        sp_prev     = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) write_mem(i, 22'($urandom), 1);
        write_mem(0, 22'h000002, 1);
        write_mem(1, 22'h000003, 1);
        write_mem(2, 22'h000004, 1);
        write_mem(3, 22'h000005, 1);

        rst = 1'b1;
        tick();
        chk_idle("reset2");
        chk("reset2_data", {10'd0, instr_data}, {10'd0, mem_m[0]});
        rst = 1'b0;
        tick();

        run_prog(4, 1, 0, 0, 8);
        run_prog(4, 0, 0, 1, 60);
        run_prog(4, 1, 0, 2, 16);
        run_prog(2, 1, 1, 0, 10);
        do_abort();
        run_prog(1, 1, 1, 1, 8);
        do_abort();
        run_prog(0, 1, 0, 0, 3);
        run_prog(40, 1, 0, 0, 36);

        run_prog(4, 1, 0, 0, 2);
        chk("pre_abort_pc", {27'd0, pc}, 2);
        instr_ready = 1'b1;
        do_abort();
        instr_ready = 1'b0;

        mode     = 1'b0;
        prog_len = 6'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", {31'd0, busy}, 1);
        write_mem(1, 22'h3FFFFF, 0);
        do_abort();
        run_prog(4, 1, 0, 0, 6);

        start = 1'b1;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("rst_start_held");
        end
        start = 1'b0;
        tick();

        for (int it = 0; it < 16; it++) begin
            int pl;
            bit md;
            bit lp;
            for (int a = 0; a < 4; a++)
                write_mem($urandom_range(0, DEPTH - 1), 22'($urandom), 1);
            pl = $urandom_range(0, 40);
            md = 1'($urandom_range(0, 1));
            lp = ($urandom_range(0, 3) == 0);
            run_prog(pl, md, lp, 1, 8 * pl + 12);
            do_abort();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
